// File: rtl/debounce_edge_capture.sv
// debounce_edge_capture
//   Per-channel debouncer and sticky edge-capture bank behind a small
//   Avalon-MM slave. It sits after the two-flop synchronizer of an input
//   pin group. Each channel's filtered level changes only after
//   DEBOUNCE_CYCLES consecutive samples that differ from the current level.
//   Accepted transitions that match MODE set a write-1-to-clear capture bit.
//   irq is the OR of all capture bits that are enabled in the mask register.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   in_sync    synchronized input levels, one bit per channel
//   address    word address: 0 DATA, 1 EDGE_CAPTURE, 2 IRQ_MASK, 3 MODE
//   read       read strobe; readdata is registered with a read latency of 1
//   write      write strobe
//   writedata  write data
//   readdata   read data; holds its value until the next read
//   irq        active-high level interrupt

module debounce_edge_capture #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_sync,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_MODE = 2'd3;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  logic [WIDTH-1:0] level;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] mask;
  logic [1:0]       mode;

  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_mux;

  // Write data above WIDTH (or above bit 1 for MODE) is intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign differ = in_sync ^ level;

  // A channel toggles on the edge that completes its run of differing samples.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < WIDTH; i++) begin
      toggle[i] = differ[i] && (cnt[i] == CNT_LAST);
    end
  end

  // The new level equals in_sync, so the toggle direction follows from in_sync.
  always_comb begin
    cap_set = '0;
    case (mode)
      MODE_RISE: cap_set = toggle & in_sync;
      MODE_FALL: cap_set = toggle & ~in_sync;
      MODE_BOTH: cap_set = toggle;
      default:   cap_set = '0;
    endcase
  end

  assign w1c = (write && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      level <= level ^ toggle;
      for (int i = 0; i < WIDTH; i++) begin
        if (!differ[i] || toggle[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // When a clear and a new capture hit the same bit on the same edge, the set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture <= '0;
    end else begin
      capture <= (capture & ~w1c) | cap_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
      mode <= MODE_RISE;
    end else if (write) begin
      if (address == ADDR_MASK) mask <= writedata[WIDTH-1:0];
      if (address == ADDR_MODE) mode <= writedata[1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = level;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = capture;
      ADDR_MASK: rd_mux[WIDTH-1:0] = mask;
      default:   rd_mux[1:0]       = mode;
    endcase
  end

  // readdata captures register state from before this edge's updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (read) begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(capture & mask);

endmodule

// File: tb/tb_debounce_edge_capture.sv
module tb_debounce_edge_capture;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] in_sync;
  logic [1:0]       address;
  logic             read;
  logic             write;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;

  debounce_edge_capture #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_sync   (in_sync),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic hold(input logic [WIDTH-1:0] v);
    @(negedge clk);
    in_sync = v;
    repeat (N + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_write(2'd2, 32'hFF);
    bus_write(2'd3, 32'h2);
    hold(8'hFF);
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
    in_sync = 8'h00;
    repeat (2) @(negedge clk);
    address = 2'd1; read = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq_async: got %b expected 0", irq); end
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata_async: got %h expected 00000000", readdata); end
    @(negedge clk);
    read = 1'b0;
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 00000000", a, d); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq_after_%0d: got %b expected 0", a, irq); end
    end
  endtask

  task automatic test_reset_partial();
    logic [31:0] exp;
    @(negedge clk);
    in_sync = 8'h01;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; address = 2'd0; read = 1'b1;
    for (int e = 1; e <= N + 1; e++) begin
      @(negedge clk);
      exp = (e == N + 1) ? 32'h1 : 32'h0;
      n_checks++;
      if (readdata !== exp) begin n_fail++; $display("FAIL partial_count_edge%0d: got %h expected %h", e, readdata, exp); end
    end
    read = 1'b0;
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    hold(8'h00);
    bus_write(2'd1, 32'hFF);
    bus_write(2'd2, 32'h01);
    @(negedge clk); in_sync = 8'h01;
    repeat (N - 1) @(negedge clk);
    in_sync = 8'h00;
    @(negedge clk); in_sync = 8'h01;
    repeat (N - 1) @(negedge clk);
    in_sync = 8'h00;
    repeat (N) @(negedge clk);
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_data: got %h expected 00000000", d); end
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_edge: got %h expected 00000000", d); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL glitch_irq: got %b expected 0", irq); end
  endtask

  task automatic test_clean_rise();
    logic [31:0] d;
    @(negedge clk); in_sync = 8'h01;
    for (int k = 1; k < N; k++) begin
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL rise_irq_early_edge%0d: got %b expected 0", k, irq); end
    end
    address = 2'd0; read = 1'b1;
    @(negedge clk);
    n_checks++;
    if (readdata !== 32'h0) begin n_fail++; $display("FAIL rise_data_at_toggle_edge: got %h expected 00000000", readdata); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL rise_irq: got %b expected 1", irq); end
    @(negedge clk);
    read = 1'b0;
    n_checks++;
    if (readdata !== 32'h1) begin n_fail++; $display("FAIL rise_data_after: got %h expected 00000001", readdata); end
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL rise_edge: got %h expected 00000001", d); end
    bus_write(2'd1, 32'h1);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b expected 0", irq); end
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_edge: got %h expected 00000000", d); end
  endtask

  task automatic test_modes();
    logic [31:0] d;
    hold(8'h09);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h08) begin n_fail++; $display("FAIL mode00_rise: got %h expected 00000008", d); end
    bus_write(2'd1, 32'hFF);
    bus_write(2'd3, 32'h1);
    hold(8'h01);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h08) begin n_fail++; $display("FAIL mode01_fall: got %h expected 00000008", d); end
    bus_write(2'd1, 32'hFF);
    hold(8'h09);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL mode01_rise: got %h expected 00000000", d); end
    bus_write(2'd3, 32'h0);
    hold(8'h01);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL mode00_fall: got %h expected 00000000", d); end
    bus_write(2'd3, 32'hFFFFFFFE);
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL mode_width: got %h expected 00000002", d); end
    hold(8'h09);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h08) begin n_fail++; $display("FAIL mode10_rise: got %h expected 00000008", d); end
    bus_write(2'd1, 32'hFF);
    hold(8'h01);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h08) begin n_fail++; $display("FAIL mode10_fall: got %h expected 00000008", d); end
    bus_write(2'd3, 32'h3);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h08) begin n_fail++; $display("FAIL mode_change_keeps: got %h expected 00000008", d); end
    bus_write(2'd1, 32'hFF);
    hold(8'h09);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL mode11_rise_edge: got %h expected 00000000", d); end
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 32'h09) begin n_fail++; $display("FAIL mode11_rise_data: got %h expected 00000009", d); end
    hold(8'h01);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL mode11_fall_edge: got %h expected 00000000", d); end
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 32'h01) begin n_fail++; $display("FAIL mode11_fall_data: got %h expected 00000001", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bus_write(2'd3, 32'h0);
    @(negedge clk); in_sync = 8'h05;
    repeat (N - 1) @(negedge clk);
    address = 2'd1; writedata = 32'h04; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h04) begin n_fail++; $display("FAIL collision_set_wins: got %h expected 00000004", d); end
    bus_write(2'd1, 32'h0);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h04) begin n_fail++; $display("FAIL w0_no_effect: got %h expected 00000004", d); end
    bus_write(2'd1, 32'h04);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_bit2: got %h expected 00000000", d); end
  endtask

  task automatic test_mask_width();
    logic [31:0] d;
    bus_write(2'd3, 32'h2);
    bus_write(2'd2, 32'h80);
    hold(8'h04);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_blocks_irq: got %b expected 0", irq); end
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h01) begin n_fail++; $display("FAIL mask_edge: got %h expected 00000001", d); end
    bus_write(2'd2, 32'hFFFFFFFF);
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'hFF) begin n_fail++; $display("FAIL mask_width: got %h expected 000000FF", d); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_all_irq: got %b expected 1", irq); end
    bus_write(2'd0, 32'hFF);
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 32'h04) begin n_fail++; $display("FAIL data_ro: got %h expected 00000004", d); end
    @(negedge clk);
    address = 2'd2; writedata = 32'h0; read = 1'b1; write = 1'b1;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    n_checks++;
    if (readdata !== 32'hFF) begin n_fail++; $display("FAIL rw_same_cycle_old: got %h expected 000000FF", readdata); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL rw_same_cycle_irq: got %b expected 0", irq); end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rw_same_cycle_new: got %h expected 00000000", d); end
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL mode_readback: got %h expected 00000002", d); end
  endtask

  initial begin
    reset_n = 1'b0; in_sync = '0; address = '0;
    read = 1'b0; write = 1'b0; writedata = '0;
    test_reset();
    test_reset_partial();
    test_glitch();
    test_clean_rise();
    test_modes();
    test_collision();
    test_mask_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
